branch_resolve: RTL and testbench

- EX-stage counterpart of the fetch-side 2-bit branch predictor.
- Records every predicted branch at fetch in an in-order queue (prediction, predicted target, fall-through PC).
- At EX resolution, pops the oldest entry and compares the actual outcome with the prediction.
- Emits the one-cycle taken/not_taken training pulses the predictor consumes, plus a mispredict flush and a 32-bit redirect address for the PC mux.

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_queue.sv | 50 +++++
 rtl/branch_resolve.sv | 63 ++++++
 tb/tb_branch_resolve.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared widths, reset PC, predictor state encodings and the
// in-flight branch entry layout used by the EX-side resolver.
package branch_pkg;
   localparam int ADDR_W = 32;
   localparam int ENTRY_W = 65;
   localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [1:0] TT  = 2'b11;
   localparam logic [1:0] T   = 2'b10;
   localparam logic [1:0] NT  = 2'b01;
   localparam logic [1:0] NNT = 2'b00;
   typedef struct packed {
      logic              pred;
      logic [ADDR_W-1:0] target;
      logic [ADDR_W-1:0] fallthru;
   } entry_t;
endpackage

// File: rtl/branch_queue.sv
// branch_queue: circular in-order buffer of in-flight branches; occupancy is
// tracked by an explicit count so full/empty never depend on pointer equality.
module branch_queue
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] data,
   input  logic               pop,
   input  logic               flush,
   output logic               full,
   output logic               empty,
   output logic [ENTRY_W-1:0] head
);
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_next;
   logic [PTR_W:0]     count;
   logic               do_push;
   logic               do_pop;

   assign do_pop      = pop && !empty;
   // a pop frees a slot in the same cycle, so a full queue can still accept
   assign do_push     = push && !flush && (!full || do_pop);
   assign rd_ptr_next = rd_ptr + PTR_W'(do_pop);
   assign full        = count == (PTR_W+1)'(DEPTH);
   assign empty       = count == '0;
   assign head        = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= flush ? rd_ptr_next : wr_ptr + PTR_W'(do_push);
         rd_ptr <= rd_ptr_next;
         count  <= flush ? '0 : count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data;
   end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: pops the oldest predicted branch at EX, compares it with the
// real outcome and emits training pulses, mispredict flush and redirect PC.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              push_pred_taken,
   input  logic [ADDR_W-1:0] push_target,
   input  logic [ADDR_W-1:0] push_fallthru,
   input  logic              resolve,
   input  logic              cond_true,
   output logic              taken,
   output logic              not_taken,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_addr,
   output logic              full,
   output logic              empty,
   output logic              err
);
   entry_t in_e;
   entry_t head_e;
   logic   res_ok;
   logic   miss;
   logic   bad;

   assign in_e   = '{pred: push_pred_taken, target: push_target, fallthru: push_fallthru};
   assign res_ok = resolve && !empty;
   assign miss   = res_ok && (head_e.pred ^ cond_true);
   assign bad    = (resolve && empty) || (push && full && !resolve);

   branch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .data  (in_e),
      .pop   (res_ok),
      .flush (miss),
      .full  (full),
      .empty (empty),
      .head  (head_e)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken         <= 1'b0;
         not_taken     <= 1'b0;
         mispredict    <= 1'b0;
         redirect_addr <= RESET_PC;
         err           <= 1'b0;
      end else begin
         taken         <= res_ok && cond_true;
         not_taken     <= res_ok && !cond_true;
         mispredict    <= miss;
         redirect_addr <= !res_ok ? redirect_addr : cond_true ? head_e.target : head_e.fallthru;
         err           <= err || bad;
      end
   end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed plan steps plus random traffic, checked against
// a queue-based reference model of the resolver's behaviour.
module tb_branch_resolve;
   localparam int DEPTH = 4;

   typedef struct {
      bit          pred;
      logic [31:0] tgt;
      logic [31:0] ft;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0;
   logic        push_pred_taken = 1'b0;
   logic [31:0] push_target = '0;
   logic [31:0] push_fallthru = '0;
   logic        resolve = 1'b0;
   logic        cond_true = 1'b0;
   logic        taken;
   logic        not_taken;
   logic        mispredict;
   logic [31:0] redirect_addr;
   logic        full;
   logic        empty;
   logic        err;

   ent_t        q[$];
   bit          m_err = 0;
   bit          m_t = 0;
   bit          m_nt = 0;
   bit          m_mp = 0;
   logic [31:0] m_ra = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   branch_resolve #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (push),
      .push_pred_taken(push_pred_taken),
      .push_target   (push_target),
      .push_fallthru (push_fallthru),
      .resolve       (resolve),
      .cond_true     (cond_true),
      .taken         (taken),
      .not_taken     (not_taken),
      .mispredict    (mispredict),
      .redirect_addr (redirect_addr),
      .full          (full),
      .empty         (empty),
      .err           (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".taken"}, 32'(taken), 32'(m_t));
      chk({tag, ".not_taken"}, 32'(not_taken), 32'(m_nt));
      chk({tag, ".mispredict"}, 32'(mispredict), 32'(m_mp));
      chk({tag, ".redirect"}, redirect_addr, m_ra);
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".err"}, 32'(err), 32'(m_err));
   endtask

   // one clock: drive inputs, apply the model's view of the edge, check after it
   task automatic step(input string tag, input bit p, input bit pp, input logic [31:0] pt,
                       input logic [31:0] pf, input bit r, input bit c);
      ent_t e;
      bit   miss;
      push = p; push_pred_taken = pp; push_target = pt; push_fallthru = pf;
      resolve = r; cond_true = c;
      @(posedge clk);
      miss = 0; m_t = 0; m_nt = 0; m_mp = 0;
      if (r && q.size() == 0) m_err = 1;
      else if (r) begin
         e = q.pop_front();
         m_t = c; m_nt = !c;
         miss = e.pred != c;
         m_mp = miss;
         m_ra = c ? e.tgt : e.ft;
         if (miss) q.delete();
      end
      if (p && !miss) begin
         if (q.size() < DEPTH) q.push_back('{pp, pt, pf});
         else m_err = 1;
      end
      #1;
      push = 0; resolve = 0;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      #1;
      q.delete(); m_err = 0; m_t = 0; m_nt = 0; m_mp = 0; m_ra = '0;
      check_all("rst");
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #2;
      q.delete();
      check_all("reset");
      #10 rst_n = 1;
      // 1: predicted taken, resolved taken
      step("t1push", 1, 1, 32'h100, 32'h44, 0, 0);
      step("t1res", 0, 0, 0, 0, 1, 1);
      chk("t1.taken_lit", 32'(taken), 32'd1);
      // 2: predicted taken, resolved not taken
      step("t2push", 1, 1, 32'h100, 32'h44, 0, 0);
      step("t2res", 0, 0, 0, 0, 1, 0);
      chk("t2.redirect_lit", redirect_addr, 32'h44);
      // 3: miss on first of three flushes queue and drops same-cycle push
      step("t3a", 1, 0, 32'h200, 32'h204, 0, 0);
      step("t3b", 1, 0, 32'h300, 32'h304, 0, 0);
      step("t3c", 1, 0, 32'h400, 32'h404, 0, 0);
      step("t3res", 1, 0, 32'h500, 32'h504, 1, 1);
      chk("t3.redirect_lit", redirect_addr, 32'h200);
      chk("t3.empty_lit", 32'(empty), 32'd1);
      // 4: fill, overflow, push+resolve while full
      for (int i = 0; i < DEPTH; i++) step("t4fill", 1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0);
      step("t4ovf", 1, 1, 32'hdead, 32'hbeef, 0, 0);
      chk("t4.err_lit", 32'(err), 32'd1);
      step("t4both", 1, 1, 32'h1010, 32'h2010, 1, 1);
      chk("t4.full_lit", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) step("t4drain", 0, 0, 0, 0, 1, 1);
      do_reset();
      // 5: resolve while empty, then wrap pointers
      step("t5empty", 0, 0, 0, 0, 1, 1);
      chk("t5.err_lit", 32'(err), 32'd1);
      step("t5seed", 1, 0, 32'h3000, 32'h3004, 0, 0);
      for (int i = 0; i < 6; i++)
         step("t5wrap", 1, 0, 32'h3100 + 32'(i * 16), 32'h3104 + 32'(i * 16), 1, 0);
      // 6: async reset with entries queued and a resolve pending
      step("t6a", 1, 1, 32'h4000, 32'h4004, 0, 0);
      step("t6b", 1, 0, 32'h5000, 32'h5004, 0, 0);
      resolve = 1; cond_true = 0;
      #2;
      rst_n = 0;
      #1;
      resolve = 0;
      q.delete(); m_err = 0; m_t = 0; m_nt = 0; m_mp = 0; m_ra = '0;
      check_all("t6rst");
      @(negedge clk);
      rst_n = 1;
      #1;
      check_all("t6rel");
      // random traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 99) < 60), 1'($urandom), $urandom, $urandom,
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 70));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
